cache_profiler_sequencer: RTL and testbench
===========================================

# cache_profiler_sequencer

Window controller and readout sequencer for the cache profiler. It drives the profiler's `enable` so counting runs for a programmed number of cycles. At window end it snapshots all profiler counters plus the elapsed-cycle count into a shadow bank, then streams them one word at a time over a valid/ready interface to the host link. It optionally re-arms for back-to-back windows.

## Interface
- `NUM_CNT`, default 8: number of 32-bit profiler counters on `cnt_in`.
- `CW`, default 32: counter and data width.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: pulse; arms a window (honoured in IDLE only).
- `stop`, input, 1: pulse; ends the current window early and suppresses re-arm.
- `continuous`, input, 1: re-arm automatically after each drain; sampled at `start`.
- `window_cycles`, input, CW: window length in cycles; sampled at `start`; 0 is treated as 1.
- `cnt_in`, input, NUM_CNT*CW: profiler counters, counter k at bits [k*CW +: CW]. Order is icache hit, miss, request; dcache hit, miss, request; icache fill latency; dcache fill latency.
- `prof_enable`, output, 1: drives the profiler `enable`. Low clears the profiler counters.
- `out_valid`, output, 1: readout word valid.
- `out_ready`, input, 1: host accepts the word.
- `out_data`, output, CW: readout word.
- `out_index`, output, 4: word index, 0..NUM_CNT.
- `out_last`, output, 1: high with word NUM_CNT.
- `out_window`, output, 16: window sequence number of the word.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN, SNAP, DRAIN.
- IDLE:
  - `prof_enable`=0 and `out_valid`=0.
  - `start`=1 latches `window_cycles` (0→1) into `remaining` and `continuous` into `cont_q`, clears `stop_pend` → CLEAR.
- CLEAR:
  - One cycle with `prof_enable`=0, which guarantees the profiler counters are zero.
  - Reloads `remaining` from the latched length and zeroes `elapsed` → RUN.
- RUN:
  - `prof_enable`=1.
  - Each cycle, `remaining` decrements and `elapsed` increments.
  - Leaves for SNAP after the cycle in which `remaining`==1, or in the same cycle that `stop`=1. A stop also sets `stop_pend`.
- SNAP:
  - One cycle with `prof_enable`=0.
  - On the closing edge, `cnt_in` is copied into shadow[0..NUM_CNT-1] and `elapsed` into shadow[NUM_CNT]. The profiler clears on that same edge; the captured values are the pre-edge ones.
  - `win_id` increments (16-bit, wraps 0xFFFF→0) → DRAIN with `idx`=0.
- DRAIN:
  - `out_valid`=1, `out_data`=shadow[idx], `out_index`=idx, `out_last`=(idx==NUM_CNT), `out_window`=`win_id`.
  - A handshake (`out_valid`&`out_ready`) advances `idx`.
  - After the handshake on the last word: go to CLEAR if `cont_q`&!`stop_pend`, otherwise IDLE.
  - `stop` in DRAIN sets `stop_pend`; the drain still completes fully.
- `start` is ignored when not in IDLE. `stop` is ignored in IDLE and CLEAR. In SNAP, `stop` sets `stop_pend`.
- `start` and `stop` both high in IDLE: start wins, then `stop` is evaluated in the first RUN cycle only if it is still high.
- Shadow bank and `out_data` are stable while `out_valid`&!`out_ready`.
- Arithmetic: `elapsed` saturates at 2^CW-1. `remaining` never underflows because 0 is mapped to 1.

## Timing
- Reset values: `prof_enable`=0, `out_valid`=0, `out_last`=0, `out_index`=0, `out_data`=0, `out_window`=0, `busy`=0, shadow=0, `win_id`=0, state=IDLE.
- `rst` mid-operation returns to IDLE on the next edge and drops `out_valid` immediately after that edge. Any partially drained window is lost.
- Latency, with `start` sampled at edge t:
  - CLEAR during cycle t+1.
  - `prof_enable` high for cycles t+2 .. t+1+W.
  - SNAP at t+2+W.
  - First `out_valid` at t+3+W.
- Drain with `out_ready` tied high: NUM_CNT+1 cycles, one word per cycle.
- Continuous mode: CLEAR occupies the cycle after the last handshake. Dead time between windows is 2 + (NUM_CNT+1) cycles minimum.
- `stop` sampled in RUN at edge s: SNAP in cycle s+1, and the elapsed word equals the RUN cycles completed including cycle s.
- All outputs are registered or decoded from registered state only; there is no combinational path from `out_ready` to `out_valid`.

## Test plan
- Single window: W=10, `continuous`=0, profiler fed 3 icache requests and 1 miss during RUN, `out_ready`=1.
  - Required: `prof_enable` high exactly 10 cycles.
  - Words 0..8 are 2, 1, 3, …, with word 8 = 10.
  - `out_last` only on index 8, `out_window`=1, then IDLE with `busy`=0.
- Backpressure: `out_ready` toggled 1,0,0,1…
  - Required: `out_data`/`out_index` hold while stalled, no word skipped or duplicated, 9 handshakes total.
- Early stop: W=100, `stop` pulsed in the 20th RUN cycle.
  - Required: SNAP the next cycle, word 8 = 20, return to IDLE even with `continuous`=1.
- Continuous: W=5, `continuous`=1, three windows drained.
  - Required: `out_window` = 1, 2, 3.
  - Each window's counters restart from 0.
  - CLEAR cycle with `prof_enable`=0 between windows.
- Edge cases: `window_cycles`=0 gives a 1-cycle window with word 8 = 1. `start` during RUN is ignored.
- Reset mid-DRAIN: assert `rst` at word index 4.
  - Required: next cycle `out_valid`=0, `prof_enable`=0, `out_window`=0.
  - A new `start` produces a full window from index 0.

Source files
------------

// File: rtl/cache_profiler_sequencer.sv
// Window controller for the cache profiler: runs the counters for a programmed
// number of cycles, snapshots them into a shadow bank and streams them out.
module cache_profiler_sequencer #(
  parameter int NUM_CNT = 8,
  parameter int CW      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [CW-1:0]         window_cycles,
  input  logic [NUM_CNT*CW-1:0] cnt_in,
  output logic                  prof_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_data,
  output logic [3:0]            out_index,
  output logic                  out_last,
  output logic [15:0]           out_window,
  output logic                  busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CNT);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SNAP, DRAIN} state_t;

  state_t               state_reg;
  logic [CW-1:0]        len_reg;
  logic [CW-1:0]        remaining_reg;
  logic [CW-1:0]        elapsed_reg;
  logic                 cont_reg;
  logic                 stop_pend_reg;
  logic [3:0]           idx_reg;
  logic [15:0]          win_id_reg;
  logic [CW-1:0]        shadow_reg [0:NUM_CNT];
  logic [NUM_CNT:0][CW-1:0] snap_words;

  // Word NUM_CNT of the snapshot is the elapsed-cycle count.
  assign snap_words = {elapsed_reg, cnt_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      remaining_reg <= '0;
      elapsed_reg   <= '0;
      cont_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
      idx_reg       <= '0;
      win_id_reg    <= '0;
      for (int i = 0; i <= NUM_CNT; i++) shadow_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg       <= (window_cycles == '0) ? CW'(1) : window_cycles;
            remaining_reg <= (window_cycles == '0) ? CW'(1) : window_cycles;
            cont_reg      <= continuous;
            stop_pend_reg <= 1'b0;
            state_reg     <= CLEAR;
          end
        end
        CLEAR: begin
          remaining_reg <= len_reg;
          elapsed_reg   <= '0;
          state_reg     <= RUN;
        end
        RUN: begin
          remaining_reg <= remaining_reg - CW'(1);
          if (elapsed_reg != '1) elapsed_reg <= elapsed_reg + CW'(1);
          if (stop) begin
            stop_pend_reg <= 1'b1;
            state_reg     <= SNAP;
          end else if (remaining_reg == CW'(1)) begin
            state_reg <= SNAP;
          end
        end
        SNAP: begin
          // The profiler clears on this edge; cnt_in still holds the window totals.
          for (int i = 0; i <= NUM_CNT; i++) shadow_reg[i] <= snap_words[i];
          win_id_reg <= win_id_reg + 16'd1;
          idx_reg    <= '0;
          if (stop) stop_pend_reg <= 1'b1;
          state_reg  <= DRAIN;
        end
        DRAIN: begin
          if (stop) stop_pend_reg <= 1'b1;
          if (out_ready) begin
            if (idx_reg == LAST_IDX) begin
              idx_reg   <= '0;
              state_reg <= (cont_reg && !stop_pend_reg && !stop) ? CLEAR : IDLE;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign prof_enable = (state_reg == RUN);
  assign out_valid   = (state_reg == DRAIN);
  assign busy        = (state_reg != IDLE);
  assign out_data    = shadow_reg[idx_reg];
  assign out_index   = idx_reg;
  assign out_last    = out_valid && (idx_reg == LAST_IDX);
  assign out_window  = win_id_reg;

endmodule

// File: tb/tb_cache_profiler_sequencer.sv
// Bench for cache_profiler_sequencer: a behavioural profiler feeds cnt_in and a
// scoreboard of expected readout words is checked on every handshake.
module tb_cache_profiler_sequencer;

  localparam int NUM_CNT = 8;
  localparam int CW      = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic                  continuous = 1'b0;
  logic [CW-1:0]         window_cycles = '0;
  logic [NUM_CNT*CW-1:0] cnt_in;
  logic                  prof_enable;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [CW-1:0]         out_data;
  logic [3:0]            out_index;
  logic                  out_last;
  logic [15:0]           out_window;
  logic                  busy;

  cache_profiler_sequencer #(.NUM_CNT(NUM_CNT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .window_cycles(window_cycles), .cnt_in(cnt_in), .prof_enable(prof_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_window(out_window), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Profiler model: 2 icache hits, 1 miss (3rd cycle), 3 requests per window.
  logic [CW-1:0] prof_cnt [NUM_CNT] = '{default: '0};
  int prof_rc = 0;
  always @(posedge clk) begin
    if (prof_enable !== 1'b1) begin
      prof_rc <= 0;
      for (int k = 0; k < NUM_CNT; k++) prof_cnt[k] <= '0;
    end else begin
      prof_rc <= prof_rc + 1;
      if (prof_rc < 2)  prof_cnt[0] <= prof_cnt[0] + 1;
      if (prof_rc == 2) prof_cnt[1] <= prof_cnt[1] + 1;
      if (prof_rc < 3)  prof_cnt[2] <= prof_cnt[2] + 1;
    end
  end

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    assign cnt_in[gi*CW +: CW] = prof_cnt[gi];
  end

  typedef struct {
    logic [CW-1:0] data;
    logic [3:0]    idx;
    logic          last;
    logic [15:0]   win;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_win = '0;

  // Expected words for a window of e RUN cycles under the profiler model above.
  task automatic push_window(input int e);
    exp_t w;
    exp_win = exp_win + 16'd1;
    for (int i = 0; i <= NUM_CNT; i++) begin
      w.data = '0;
      if (i == 0) w.data = (e < 2) ? CW'(e) : CW'(2);
      if (i == 1) w.data = (e >= 3) ? CW'(1) : CW'(0);
      if (i == 2) w.data = (e < 3) ? CW'(e) : CW'(3);
      if (i == NUM_CNT) w.data = CW'(e);
      w.idx  = 4'(i);
      w.last = (i == NUM_CNT);
      w.win  = exp_win;
      sb.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      $display("word win=%0d idx=%0d last=%0d data=%0d", out_window, out_index, out_last, out_data);
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_word: got idx=%0d data=%0d, expected no word", out_index, out_data);
      end else begin
        mon_e = sb.pop_front();
        if ({out_data, out_index, out_last, out_window} !== {mon_e.data, mon_e.idx, mon_e.last, mon_e.win})
          $display("FAIL word: got data=%0d idx=%0d last=%0d win=%0d, expected data=%0d idx=%0d last=%0d win=%0d",
                   out_data, out_index, out_last, out_window, mon_e.data, mon_e.idx, mon_e.last, mon_e.win);
        else passes++;
      end
    end
  end

  task automatic pulse_start(input logic [CW-1:0] w, input logic cont);
    @(posedge clk); #1;
    window_cycles = w;
    continuous    = cont;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({prof_enable, out_valid, out_last, busy} !== 4'b0000)
      $display("FAIL reset_flags: got pe/v/last/busy=%b, expected 0000", {prof_enable, out_valid, out_last, busy});
    else passes++;
    checks++;
    if ({out_data, out_index, out_window} !== '0)
      $display("FAIL reset_data: got data=%0d idx=%0d win=%0d, expected 0", out_data, out_index, out_window);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_window();
    int pe_cnt = 0, first_pe = 0, first_v = 0;
    bit done = 0;
    out_ready = 1'b1;
    push_window(10);
    pulse_start(10, 1'b0);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (prof_enable) begin
        pe_cnt++;
        if (first_pe == 0) first_pe = n;
      end
      if (out_valid && first_v == 0) first_v = n;
      if (!busy) begin done = 1; break; end
    end
    checks++;
    if (!done) $display("FAIL single_timeout: got busy=%b, expected idle within 200 cycles", busy); else passes++;
    checks++;
    if (pe_cnt != 10) $display("FAIL single_enable_cycles: got %0d, expected 10", pe_cnt); else passes++;
    checks++;
    if (first_pe != 2) $display("FAIL single_enable_latency: got %0d, expected 2", first_pe); else passes++;
    checks++;
    if (first_v != 13) $display("FAIL single_valid_latency: got %0d, expected 13", first_v); else passes++;
    checks++;
    if (sb.size() != 0) $display("FAIL single_words_left: got %0d, expected 0", sb.size()); else passes++;
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit stalled = 0, done = 0;
    logic [CW-1:0] held_data = '0;
    logic [3:0] held_idx = '0;
    int hs = 0;
    push_window(10);
    pulse_start(10, 1'b0);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      out_ready = pat[k % 4];
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_data !== held_data || out_index !== held_idx)
          $display("FAIL bp_hold: got data=%0d idx=%0d, expected data=%0d idx=%0d", out_data, out_index, held_data, held_idx);
        else passes++;
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_idx  = out_index;
      if (out_valid && out_ready) hs++;
      if (!busy) begin done = 1; break; end
    end
    out_ready = 1'b1;
    checks++;
    if (!done || hs != 9) $display("FAIL bp_handshakes: got %0d (done=%0d), expected 9", hs, done); else passes++;
    checks++;
    if (sb.size() != 0) $display("FAIL bp_words_left: got %0d, expected 0", sb.size()); else passes++;
  endtask

  task automatic test_early_stop();
    int rc = 0;
    bit chk_snap = 0, done = 0, late_busy = 0;
    out_ready = 1'b1;
    push_window(20);
    pulse_start(100, 1'b1);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      if (chk_snap) begin
        chk_snap = 0;
        checks++;
        if ({prof_enable, busy, out_valid} !== 3'b010)
          $display("FAIL stop_snap: got pe/busy/valid=%b, expected 010", {prof_enable, busy, out_valid});
        else passes++;
      end
      if (prof_enable) begin
        rc++;
        if (rc == 20) begin stop = 1'b1; chk_snap = 1; end
      end
      if (!busy) begin done = 1; break; end
    end
    repeat (5) begin
      @(negedge clk);
      if (busy) late_busy = 1;
    end
    checks++;
    if (!done || late_busy) $display("FAIL stop_idle: got done=%0d rearmed=%0d, expected done=1 rearmed=0", done, late_busy);
    else passes++;
    checks++;
    if (rc != 20) $display("FAIL stop_run_cycles: got %0d, expected 20", rc); else passes++;
    checks++;
    if (sb.size() != 0) $display("FAIL stop_words_left: got %0d, expected 0", sb.size()); else passes++;
  endtask

  task automatic test_continuous();
    logic [15:0] third;
    int wins = 0, stage = 0;
    bit stopped = 0, done = 0;
    out_ready = 1'b1;
    third = exp_win + 16'd3;
    push_window(5);
    push_window(5);
    push_window(5);
    pulse_start(5, 1'b1);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      if (stage == 2) begin
        stage = 0;
        checks++;
        if (prof_enable !== 1'b1) $display("FAIL cont_rerun: got pe=%b, expected 1", prof_enable); else passes++;
      end
      if (stage == 1) begin
        stage = 2;
        checks++;
        if ({prof_enable, busy, out_valid} !== 3'b010)
          $display("FAIL cont_clear: got pe/busy/valid=%b, expected 010", {prof_enable, busy, out_valid});
        else passes++;
      end
      if (out_valid && out_ready && out_last) begin
        wins++;
        if (wins < 3) stage = 1;
      end
      if (out_valid && out_window == third && !stopped) begin
        stop = 1'b1;
        stopped = 1;
      end
      if (!busy) begin done = 1; break; end
    end
    checks++;
    if (!done || wins != 3) $display("FAIL cont_windows: got %0d (done=%0d), expected 3", wins, done); else passes++;
    checks++;
    if (sb.size() != 0) $display("FAIL cont_words_left: got %0d, expected 0", sb.size()); else passes++;
  endtask

  task automatic test_edge_cases();
    int pe = 0;
    bit done = 0;
    out_ready = 1'b1;
    push_window(1);
    pulse_start(0, 1'b0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (prof_enable) pe++;
      if (!busy) begin done = 1; break; end
    end
    checks++;
    if (!done || pe != 1) $display("FAIL zero_window: got %0d enable cycles (done=%0d), expected 1", pe, done); else passes++;

    pe = 0;
    done = 0;
    push_window(10);
    pulse_start(10, 1'b0);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (prof_enable) begin
        pe++;
        if (pe == 3) begin window_cycles = 3; start = 1'b1; end
      end
      if (!busy) begin done = 1; break; end
    end
    checks++;
    if (!done || pe != 10) $display("FAIL start_in_run: got %0d enable cycles (done=%0d), expected 10", pe, done); else passes++;
    checks++;
    if (sb.size() != 0) $display("FAIL edge_words_left: got %0d, expected 0", sb.size()); else passes++;
  endtask

  task automatic test_reset_mid_drain();
    bit found = 0, done = 0;
    out_ready = 1'b1;
    push_window(4);
    pulse_start(4, 1'b0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid && out_index == 4'd3) begin found = 1; break; end
    end
    checks++;
    if (!found) $display("FAIL rst_reach_idx: got no word 3, expected word 3 within 100 cycles"); else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, prof_enable, busy} !== 3'b000 || out_window !== 16'd0)
      $display("FAIL rst_mid_drain: got valid/pe/busy=%b win=%0d, expected 000 win=0", {out_valid, prof_enable, busy}, out_window);
    else passes++;
    sb.delete();
    exp_win = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    push_window(4);
    pulse_start(4, 1'b0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
    end
    checks++;
    if (!done || sb.size() != 0) $display("FAIL rst_new_window: got %0d words left (done=%0d), expected 0", sb.size(), done);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_backpressure();
    test_early_stop();
    test_continuous();
    test_edge_cases();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
